instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, little-endian word swap, 2-bit branch
// predictor and the IF/ID pipeline register feeding decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [1:0]  BHT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_stall,
  input  logic        PC_write,
  input  logic        flush,
  input  logic [31:0] PC_correct,
  input  logic        br_update,
  input  logic        br_taken,
  input  logic [31:0] ICACHE_rdata,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  output logic [29:0] instruction_1,
  output logic [31:0] PC_1,
  output logic        prev_taken_1
);

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [29:0] BUBBLE    = 30'h0000_0004;

  logic [31:0] pc_q, pc_d;
  logic [29:0] inst1_q, inst1_d;
  logic [31:0] pc1_q, pc1_d;
  logic        pt1_q, pt1_d;
  logic [1:0]  bht_q, bht_d;

  logic [31:0] inst;
  logic [31:0] sbImm, ujImm, target;
  logic        isBranch, isJal, predTaken;

  assign inst = {ICACHE_rdata[7:0], ICACHE_rdata[15:8],
                 ICACHE_rdata[23:16], ICACHE_rdata[31:24]};

  assign sbImm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign ujImm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  assign isBranch  = (inst[6:0] == OP_BRANCH);
  assign isJal     = (inst[6:0] == OP_JAL);
  assign predTaken = isJal || (isBranch && bht_q[1]);
  assign target    = pc_q + (isJal ? ujImm : sbImm);

  assign ICACHE_ren    = ~rst;
  assign ICACHE_addr   = pc_q[31:2];
  assign instruction_1 = inst1_q;
  assign PC_1          = pc1_q;
  assign prev_taken_1  = pt1_q;

  // A memory stall freezes everything; otherwise flush outranks the load-use hold.
  always_comb begin
    pc_d    = pc_q;
    inst1_d = inst1_q;
    pc1_d   = pc1_q;
    pt1_d   = pt1_q;
    bht_d   = bht_q;
    if (!memory_stall) begin
      if (flush) begin
        pc_d    = PC_correct;
        inst1_d = BUBBLE;
        pc1_d   = pc_q;
        pt1_d   = 1'b0;
      end else if (!PC_write) begin
        pc_d    = predTaken ? target : pc_q + 32'd4;
        inst1_d = inst[31:2];
        pc1_d   = pc_q;
        pt1_d   = predTaken;
      end
      if (br_update) begin
        if (br_taken) begin
          bht_d = (bht_q == 2'b11) ? 2'b11 : bht_q + 2'b01;
        end else begin
          bht_d = (bht_q == 2'b00) ? 2'b00 : bht_q - 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst1_q <= BUBBLE;
      pc1_q   <= 32'h0000_0000;
      pt1_q   <= 1'b0;
      bht_q   <= BHT_INIT;
    end else begin
      pc_q    <= pc_d;
      inst1_q <= inst1_d;
      pc1_q   <= pc1_d;
      pt1_q   <= pt1_d;
      bht_q   <= bht_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch, scored against an arithmetic model
// of the fetch rules, plus a set of directed scenarios.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_stall, PC_write, flush, br_update, br_taken;
  logic [31:0] PC_correct, ICACHE_rdata;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr, instruction_1;
  logic [31:0] PC_1;
  logic        prev_taken_1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mPc, mPc1;
  logic [29:0] mInst1;
  logic        mPt1;
  int          mCtr;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .memory_stall (memory_stall),
    .PC_write     (PC_write),
    .flush        (flush),
    .PC_correct   (PC_correct),
    .br_update    (br_update),
    .br_taken     (br_taken),
    .ICACHE_rdata (ICACHE_rdata),
    .ICACHE_ren   (ICACHE_ren),
    .ICACHE_addr  (ICACHE_addr),
    .instruction_1(instruction_1),
    .PC_1         (PC_1),
    .prev_taken_1 (prev_taken_1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swap(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc    = 32'h0000_0000;
    mInst1 = 30'h4;
    mPc1   = 32'h0;
    mPt1   = 1'b0;
    mCtr   = 1;
  endtask

  // The model works from the instruction's meaning: signed offsets as integers.
  task automatic modelStep(input logic stall, input logic wr, input logic fl,
                           input logic [31:0] corr, input logic bu, input logic bt,
                           input logic [31:0] rdata);
    logic [31:0] inst, npc;
    int sbOff, jOff;
    logic taken;
    inst  = swap(rdata);
    sbOff = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
            + int'(inst[11:8]) * 2;
    jOff  = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
            + int'(inst[30:21]) * 2;
    taken = (inst[6:0] == 7'd111) || (inst[6:0] == 7'd99 && mCtr >= 2);
    if (stall)      npc = mPc;
    else if (fl)    npc = corr;
    else if (wr)    npc = mPc;
    else if (taken) npc = mPc + ((inst[6:0] == 7'd111) ? 32'(jOff) : 32'(sbOff));
    else            npc = mPc + 32'd4;
    if (!stall) begin
      if (fl) begin
        mInst1 = 30'h4; mPc1 = mPc; mPt1 = 1'b0;
      end else if (!wr) begin
        mInst1 = inst[31:2]; mPc1 = mPc; mPt1 = taken;
      end
      if (bu) mCtr = bt ? ((mCtr < 3) ? mCtr + 1 : 3) : ((mCtr > 0) ? mCtr - 1 : 0);
    end
    mPc = npc;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_ren"},  32'(ICACHE_ren),    32'(!rst));
    checkOutput({tag, "_addr"}, 32'(ICACHE_addr),   32'(mPc[31:2]));
    checkOutput({tag, "_inst"}, 32'(instruction_1), 32'(mInst1));
    checkOutput({tag, "_pc1"},  PC_1,               mPc1);
    checkOutput({tag, "_pt"},   32'(prev_taken_1),  32'(mPt1));
  endtask

  task automatic applyStimulus(input string tag, input logic stall, input logic wr,
                               input logic fl, input logic [31:0] corr,
                               input logic bu, input logic bt, input logic [31:0] rdata);
    memory_stall = stall; PC_write = wr; flush = fl; PC_correct = corr;
    br_update = bu; br_taken = bt; ICACHE_rdata = rdata;
    @(posedge clk);
    modelStep(stall, wr, fl, corr, bu, bt, rdata);
    #1;
    compareAll(tag);
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ8 = 32'hFE00_0CE3;
  localparam logic [31:0] JAL32 = 32'h0200_006F;

  initial begin
    logic [31:0] w;
    int sel;
    rst = 1'b1; memory_stall = 0; PC_write = 0; flush = 0; PC_correct = 0;
    br_update = 0; br_taken = 0; ICACHE_rdata = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll("reset");
    @(negedge clk) rst = 1'b0;

    // addi x1,x0,5 fetched from PC 0
    applyStimulus("addi", 0, 0, 0, 0, 0, 0, swap(32'h0050_0093));
    checkOutput("addi_inst_const", 32'(instruction_1), 32'h0014_0024);
    checkOutput("addi_addr_const", 32'(ICACHE_addr), 32'h1);

    // JAL +0x20 at 0x10
    applyStimulus("toJal", 0, 0, 1, 32'h10, 0, 0, swap(NOP));
    applyStimulus("jal", 0, 0, 0, 0, 0, 0, swap(JAL32));
    checkOutput("jal_addr_const", 32'(ICACHE_addr), 32'hC);
    checkOutput("jal_pt_const", 32'(prev_taken_1), 32'h1);

    // BEQ -8 at 0x40: weakly not-taken first, then strongly taken
    applyStimulus("toBeq", 0, 0, 1, 32'h40, 0, 0, swap(NOP));
    applyStimulus("beqNt", 0, 0, 0, 0, 0, 0, swap(BEQ8));
    checkOutput("beqNt_addr_const", 32'(ICACHE_addr), 32'h11);
    applyStimulus("train1", 0, 0, 0, 0, 1, 1, swap(NOP));
    applyStimulus("train2", 0, 0, 1, 32'h40, 1, 1, swap(NOP));
    applyStimulus("beqT", 0, 0, 0, 0, 0, 0, swap(BEQ8));
    checkOutput("beqT_addr_const", 32'(ICACHE_addr), 32'hE);
    checkOutput("beqT_pt_const", 32'(prev_taken_1), 32'h1);

    // stall dominates flush and predictor update
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1, 0, 1, 32'h200, 1, 0, swap(JAL32));
      checkOutput("stall_addr_const", 32'(ICACHE_addr), 32'hE);
    end
    applyStimulus("unstall", 0, 0, 1, 32'h200, 0, 0, swap(JAL32));
    checkOutput("unstall_addr_const", 32'(ICACHE_addr), 32'h80);

    // flush beats PC_write
    applyStimulus("flushWr", 0, 1, 1, 32'h100, 0, 0, swap(JAL32));
    checkOutput("flushWr_addr_const", 32'(ICACHE_addr), 32'h40);
    checkOutput("flushWr_inst_const", 32'(instruction_1), 32'h4);
    applyStimulus("hold", 0, 1, 0, 0, 0, 0, swap(JAL32));

    // sequential wrap at the top of the address space
    applyStimulus("toTop", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, swap(NOP));
    applyStimulus("wrap", 0, 0, 0, 0, 0, 0, swap(NOP));
    checkOutput("wrap_addr_const", 32'(ICACHE_addr), 32'h0);

    // asynchronous reset mid-run with PC at 0x48
    applyStimulus("to48", 0, 0, 1, 32'h48, 0, 0, swap(NOP));
    #2 rst = 1'b1;
    #1;
    modelReset();
    compareAll("midReset");
    @(negedge clk) rst = 1'b0;
    applyStimulus("postReset", 0, 0, 0, 0, 0, 0, swap(BEQ8));
    checkOutput("postReset_addr_const", 32'(ICACHE_addr), 32'h1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 3);
      w = $urandom;
      if (sel == 1) w = {w[31:7], 7'b1100011};
      else if (sel == 2) w = {w[31:7], 7'b1101111};
      else if (sel == 3) w = NOP;
      applyStimulus("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0), {$urandom} & 32'hFFFF_FFFC,
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, swap(w));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
